// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between a processor
// port (A) and a debug/loader port (B); one access per cycle, ack one cycle later.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  ack_a,
  output logic                  err_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_b,
  output logic                  err_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  logic                  last_grant_b;
  logic                  elig_a, elig_b;
  logic                  grant_a, grant_b, grant_any;
  logic                  sel_we, sel_ok;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // A port whose ack is high this cycle sits out, so a held request is not re-issued.
  assign elig_a    = req_a & ~ack_a;
  assign elig_b    = req_b & ~ack_b;
  assign grant_a   = elig_a & (~elig_b | last_grant_b);
  assign grant_b   = elig_b & ~grant_a;
  assign grant_any = grant_a | grant_b;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant_a) begin
      sel_we    = we_a;
      sel_addr  = addr_a;
      sel_wdata = wdata_a;
    end else if (grant_b) begin
      sel_we    = we_b;
      sel_addr  = addr_b;
      sel_wdata = wdata_b;
    end
    sel_ok = addr_in_range(sel_addr);
  end

  // Memory pins are forced quiet while reset is high so no access leaks through.
  always_comb begin
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    if (!reset && grant_any) begin
      mem_write   = sel_ok & sel_we;
      mem_read    = sel_ok & ~sel_we;
      mem_address = sel_addr;
      mem_data_in = sel_wdata;
    end
  end

  // Grant cycle -> ack cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_b <= 1'b1;
      ack_a        <= 1'b0;
      err_a        <= 1'b0;
      rdata_a      <= '0;
      ack_b        <= 1'b0;
      err_b        <= 1'b0;
      rdata_b      <= '0;
    end else begin
      ack_a <= grant_a;
      err_a <= grant_a & ~sel_ok;
      ack_b <= grant_b;
      err_b <= grant_b & ~sel_ok;
      if (grant_a) last_grant_b <= 1'b0;
      else if (grant_b) last_grant_b <= 1'b1;
      if (grant_a && !sel_we) rdata_a <= sel_ok ? mem_data_out : '0;
      if (grant_b && !sel_we) rdata_b <= sel_ok ? mem_data_out : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 50x8 memory on the memory pins.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, we_a, req_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, err_a, ack_b, err_b;
  logic [7:0] rdata_a, rdata_b;
  logic       mem_write, mem_read;
  logic [5:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;

  logic [7:0] mem [0:49] = '{default: 8'h00};

  int n_checks = 0;
  int n_fail   = 0;
  int acks     = 0;

  dmem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(50)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .err_a(err_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .err_b(err_b), .rdata_b(rdata_b),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  assign mem_data_out = (int'(mem_address) < 50) ? mem[mem_address] : 8'h00;

  always @(posedge clk)
    if (mem_write && int'(mem_address) < 50) mem[mem_address] <= mem_data_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd5; wdata_a = 8'hA5;
    req_b = 1'b0; we_b = 1'b0; addr_b = 6'd0; wdata_b = 8'h00;

    // Reset state, with a request already pending
    mid();
    check("rst_ack_a", ack_a, 0);
    check("rst_ack_b", ack_b, 0);
    check("rst_err", {err_a, err_b}, 0);
    check("rst_rdata", {rdata_a, rdata_b}, 0);
    check("rst_strobes", {mem_write, mem_read}, 0);
    step(); reset = 1'b0;

    // A writes addr 5 = A5
    mid();
    check("t1_mem_write", mem_write, 1);
    check("t1_mem_read", mem_read, 0);
    check("t1_mem_addr", mem_address, 5);
    check("t1_mem_din", mem_data_in, 8'hA5);
    check("t1_ack_early", ack_a, 0);
    step(); req_a = 1'b0;
    mid();
    check("t1_ack_a", ack_a, 1);
    check("t1_err_a", err_a, 0);
    check("t1_idle", {mem_write, mem_read}, 0);
    check("t1_mem5", mem[5], 8'hA5);

    // A reads addr 5 back
    step(); req_a = 1'b1; we_a = 1'b0;
    mid();
    check("t2_ack_cleared", ack_a, 0);
    check("t2_mem_read", mem_read, 1);
    check("t2_mem_write", mem_write, 0);
    step(); req_a = 1'b0;
    mid();
    check("t2_ack_a", ack_a, 1);
    check("t2_rdata_a", rdata_a, 8'hA5);
    check("t2_err_a", err_a, 0);
    check("t2_rdata_b", rdata_b, 0);

    // Contention from reset: A writes 1=11, B reads 1; grants A,B,A,B
    step(); reset = 1'b1; #2; reset = 1'b0;
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd1; wdata_a = 8'h11;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'd1;
    mid();
    check("t3_rdata_a_rst", rdata_a, 0);
    check("t3_c0_grant_a", {mem_write, mem_read}, 2'b10);
    check("t3_c0_addr", mem_address, 1);
    step(); mid();
    check("t3_c1_acks", {ack_a, ack_b}, 2'b10);
    check("t3_c1_grant_b", {mem_write, mem_read}, 2'b01);
    check("t3_c1_mem_dout", mem_data_out, 8'h11);
    step(); mid();
    check("t3_c2_acks", {ack_a, ack_b}, 2'b01);
    check("t3_c2_rdata_b", rdata_b, 8'h11);
    check("t3_c2_grant_a", {mem_write, mem_read}, 2'b10);
    step(); mid();
    check("t3_c3_acks", {ack_a, ack_b}, 2'b10);
    check("t3_c3_grant_b", {mem_write, mem_read}, 2'b01);
    step(); req_a = 1'b0; req_b = 1'b0;
    mid();
    check("t3_c4_acks", {ack_a, ack_b}, 2'b01);
    check("t3_c4_rdata_b", rdata_b, 8'h11);
    check("t3_c4_idle", {mem_write, mem_read}, 0);

    // B reads out-of-range addresses 50 and 63
    step(); req_b = 1'b1; we_b = 1'b0; addr_b = 6'd50;
    mid();
    check("t4_oor50_strobes", {mem_write, mem_read}, 0);
    check("t4_oor50_ack_early", ack_b, 0);
    step(); addr_b = 6'd63;
    mid();
    check("t4_oor50_ack_err", {ack_b, err_b}, 2'b11);
    check("t4_oor50_rdata_b", rdata_b, 0);
    step();
    mid();
    check("t4_oor63_strobes", {mem_write, mem_read}, 0);
    check("t4_oor63_ack_early", {ack_b, err_b}, 0);
    step(); req_b = 1'b0;
    mid();
    check("t4_oor63_ack_err", {ack_b, err_b}, 2'b11);
    check("t4_oor63_rdata_b", rdata_b, 0);
    step();
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd5;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'd1;
    mid();
    check("t4_contend_read", mem_read, 1);
    check("t4_contend_addr_a", mem_address, 5);
    step(); req_a = 1'b0; req_b = 1'b0;
    mid();
    check("t4_contend_acks", {ack_a, ack_b}, 2'b10);
    check("t4_contend_rdata_a", rdata_a, 8'hA5);

    // A holds req for 6 cycles: acks every other cycle
    step(); req_a = 1'b1; we_a = 1'b0; addr_a = 6'd1;
    for (int k = 0; k < 6; k++) begin
      mid();
      check($sformatf("t5_ack_c%0d", k), ack_a, k % 2);
      if (ack_a) acks++;
      if (k < 5) step();
    end
    step(); req_a = 1'b0;
    mid();
    check("t5_ack_after", ack_a, 0);
    check("t5_ack_count", acks, 3);
    check("t5_rdata_a", rdata_a, 8'h11);

    // Reset lands mid-grant of a write to addr 7
    step(); req_a = 1'b1; we_a = 1'b1; addr_a = 6'd7; wdata_a = 8'h77;
    mid();
    check("t6_grant_write", mem_write, 1);
    check("t6_grant_addr", mem_address, 7);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_strobes", {mem_write, mem_read}, 0);
    check("t6_rst_rdata", {rdata_a, rdata_b}, 0);
    check("t6_rst_ack", {ack_a, err_a}, 0);
    step(); reset = 1'b0;
    mid();
    check("t6_dropped_ack", ack_a, 0);
    check("t6_mem7_unwritten", mem[7], 0);
    check("t6_regrant", {mem_write, mem_address}, {1'b1, 6'd7});
    step(); req_a = 1'b0;
    mid();
    check("t6_ack_err", {ack_a, err_a}, 2'b10);
    check("t6_mem7", mem[7], 8'h77);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
